// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets NREQ requesters share one FIFO write port.
// Each grant holds the port for a burst of up to MAXBURST words.
module fifo_wr_arbiter #(
   parameter int DATASIZE = 8,
   parameter int NREQ     = 4,
   parameter int MAXBURST = 4
) (
   input  logic                     wclk_i,
   input  logic                     wrst_n_i,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ*DATASIZE-1:0] data_i,
   output logic [NREQ-1:0]          ack_o,
   output logic [NREQ-1:0]          grant_o,
   output logic                     wen,
   output logic [DATASIZE-1:0]      din,
   input  logic                     fifo_full,
   input  logic                     fifo_almost_full,
   output logic                     busy_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [NREQ-1:0]       grant_q, grant_d;
   logic [PW-1:0]         owner_q, owner_d;
   logic [PW-1:0]         rrPtr_q, rrPtr_d;
   logic [3:0]            burstCnt_q, burstCnt_d;
   logic                  pickValid;
   logic [PW-1:0]         pickIdx;
   logic                  ownerReq;
   logic [DATASIZE-1:0]   ownerData;
   logic                  lastWord;

   function automatic logic [PW-1:0] rotIdx(input logic [PW-1:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= NREQ) s = s - NREQ;
      return PW'(s);
   endfunction

   // Scan from the highest offset down so the requester closest to rrPtr wins.
   always_comb begin
      pickValid = 1'b0;
      pickIdx   = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_i[rotIdx(rrPtr_q, i)]) begin
            pickValid = 1'b1;
            pickIdx   = rotIdx(rrPtr_q, i);
         end
      end
   end

   always_comb begin
      ownerReq  = 1'b0;
      ownerData = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_q[k]) begin
            ownerReq  = req_i[k];
            ownerData = data_i[k*DATASIZE +: DATASIZE];
         end
      end
   end

   assign busy_o   = (state_q == BURST);
   assign grant_o  = grant_q;
   assign wen      = busy_o & ownerReq & ~fifo_full;
   assign din      = ownerData;
   assign ack_o    = grant_q & {NREQ{wen}};
   assign lastWord = wen & (((burstCnt_q + 4'd1) == 4'(MAXBURST)) | fifo_almost_full);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      rrPtr_d    = rrPtr_q;
      burstCnt_d = burstCnt_q;
      case (state_q)
         IDLE: begin
            if (pickValid && !fifo_full) begin
               state_d    = BURST;
               grant_d    = NREQ'(1) << pickIdx;
               owner_d    = pickIdx;
               burstCnt_d = '0;
            end
         end
         BURST: begin
            if (wen && burstCnt_q != 4'hF) burstCnt_d = burstCnt_q + 4'd1;
            if (!ownerReq || lastWord) begin
               state_d = IDLE;
               grant_d = '0;
               rrPtr_d = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + PW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk_i or negedge wrst_n_i) begin
      if (!wrst_n_i) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         rrPtr_q    <= '0;
         burstCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         rrPtr_q    <= rrPtr_d;
         burstCnt_q <= burstCnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int MB = 4;

   logic             wclk = 1'b0;
   logic             wrstN = 1'b0;
   logic [NR-1:0]    req = '0;
   logic [NR*DW-1:0] data = '0;
   logic             full = 1'b0;
   logic             afull = 1'b0;
   logic [NR-1:0]    ack, grant;
   logic             wen, busy;
   logic [DW-1:0]    din;

   int total = 0;
   int bad = 0;

   fifo_wr_arbiter #(.DATASIZE(DW), .NREQ(NR), .MAXBURST(MB)) dut (
      .wclk_i(wclk), .wrst_n_i(wrstN), .req_i(req), .data_i(data),
      .ack_o(ack), .grant_o(grant), .wen(wen), .din(din),
      .fifo_full(full), .fifo_almost_full(afull), .busy_o(busy)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic [NR-1:0] req;
      logic          full;
      logic          afull;
      logic [NR-1:0] grant;
      logic          wen;
      logic [NR-1:0] ack;
      logic [DW-1:0] din;
      logic          busy;
   } vec_t;

   vec_t tbl[10];

   // Reference model: owner index (-1 when idle), words written in this grant, rotation pointer.
   int mOwner, mCnt, mPtr;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NR-1:0] r, input logic f, input logic af);
      req   = r;
      full  = f;
      afull = af;
   endtask

   task automatic doReset();
      wrstN = 1'b0;
      applyStimulus('0, 1'b0, 1'b0);
      repeat (2) @(posedge wclk);
      #1 wrstN = 1'b1;
   endtask

   task automatic nextCycle();
      @(posedge wclk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] wq[$];
      int            cq[$];
      int            oq[$];
      int            expCyc[6];
      int            multiAck;
      logic          eBusy, eWen, found;
      logic [NR-1:0] eGrant, eAck;

      tbl[0] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};
      tbl[1] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};
      tbl[2] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'hC2, 1'b1};
      tbl[3] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 8'h00, 1'b1};
      tbl[4] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hC2, 1'b1};
      tbl[5] = '{4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};
      tbl[6] = '{4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA0, 1'b1};
      tbl[7] = '{4'b0100, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 8'h00, 1'b1};
      tbl[8] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0};
      tbl[9] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'hC2, 1'b1};

      // Reset values while reset is held.
      #2;
      checkOutput("reset_grant", grant, 0);
      checkOutput("reset_wen", wen, 0);
      checkOutput("reset_ack", ack, 0);
      checkOutput("reset_busy", busy, 0);

      // Directed vector table.
      doReset();
      data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].req, tbl[i].full, tbl[i].afull);
         @(negedge wclk);
         checkOutput($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
         checkOutput($sformatf("tbl%0d_wen", i), wen, tbl[i].wen);
         checkOutput($sformatf("tbl%0d_ack", i), ack, tbl[i].ack);
         checkOutput($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         if (tbl[i].wen) checkOutput($sformatf("tbl%0d_din", i), din, tbl[i].din);
         nextCycle();
      end

      // Single requester with incrementing data: A0..A3, one idle cycle, then A4, A5.
      doReset();
      data = '0;
      data[2*DW +: DW] = 8'hA0;
      applyStimulus(4'b0100, 1'b0, 1'b0);
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge wclk);
         if (cyc == 0) checkOutput("single_grant_c0", grant, 4'b0000);
         if (cyc == 1) checkOutput("single_grant_c1", grant, 4'b0100);
         if (wen) begin
            wq.push_back(din);
            cq.push_back(cyc);
         end
         nextCycle();
         if (ack[2] === 1'b1 || wq.size() > 0) data[2*DW +: DW] = 8'hA0 + DW'(wq.size());
         if (wq.size() >= 6) req = '0;
      end
      expCyc = '{1, 2, 3, 4, 6, 7};
      checkOutput("single_count", wq.size(), 6);
      for (int j = 0; j < 6 && j < wq.size(); j++) begin
         checkOutput($sformatf("single_data%0d", j), wq[j], 8'hA0 + j);
         checkOutput($sformatf("single_cycle%0d", j), cq[j], expCyc[j]);
      end

      // All requesters continuously: rotation 0,1,2,3,0 with MB words each.
      doReset();
      data = {8'h44, 8'h33, 8'h22, 8'h11};
      applyStimulus(4'b1111, 1'b0, 1'b0);
      multiAck = 0;
      for (int cyc = 0; cyc < 28; cyc++) begin
         @(negedge wclk);
         if (!$onehot0(ack)) multiAck++;
         if (wen) begin
            for (int k = 0; k < NR; k++) if (ack[k]) oq.push_back(k);
         end
         nextCycle();
      end
      checkOutput("fair_multi_ack", multiAck, 0);
      checkOutput("fair_enough_writes", (oq.size() >= 20), 1);
      for (int j = 0; j < 20 && j < oq.size(); j++)
         checkOutput($sformatf("fair_owner%0d", j), oq[j], (j / MB) % NR);

      // Reset pulsed mid-burst clears outputs without a clock edge.
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0);
      nextCycle();
      @(negedge wclk);
      checkOutput("rst_pre_wen", wen, 1);
      #2 wrstN = 1'b0;
      #1;
      checkOutput("rst_async_wen", wen, 0);
      checkOutput("rst_async_grant", grant, 0);
      checkOutput("rst_async_ack", ack, 0);
      @(posedge wclk);
      #1;
      checkOutput("rst_held_wen", wen, 0);
      wrstN = 1'b1;
      applyStimulus(4'b1010, 1'b0, 1'b0);
      @(negedge wclk);
      checkOutput("rst_after_idle", grant, 0);
      nextCycle();
      @(negedge wclk);
      checkOutput("rst_after_grant", grant, 4'b0010);
      nextCycle();

      // Randomized run against the transaction-level model.
      doReset();
      mOwner = -1;
      mCnt   = 0;
      mPtr   = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < NR; k++) if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
         full  = ($urandom_range(0, 4) == 0);
         afull = ($urandom_range(0, 5) == 0);
         for (int k = 0; k < NR; k++) data[k*DW +: DW] = DW'($urandom);
         @(negedge wclk);
         eBusy  = (mOwner >= 0);
         eGrant = eBusy ? NR'(1 << mOwner) : '0;
         eWen   = eBusy && req[mOwner] && !full;
         eAck   = eWen ? eGrant : '0;
         checkOutput("rand_grant", grant, eGrant);
         checkOutput("rand_wen", wen, eWen);
         checkOutput("rand_ack", ack, eAck);
         checkOutput("rand_busy", busy, eBusy);
         if (eBusy) checkOutput("rand_din", din, data[mOwner*DW +: DW]);
         @(posedge wclk);
         if (!eBusy) begin
            if (req != 0 && !full) begin
               found = 1'b0;
               for (int k = 0; k < NR; k++) begin
                  if (!found && req[(mPtr + k) % NR]) begin
                     mOwner = (mPtr + k) % NR;
                     found  = 1'b1;
                  end
               end
               mCnt = 0;
            end
         end else begin
            if (eWen) mCnt++;
            if (!req[mOwner] || (eWen && mCnt == MB) || (eWen && afull)) begin
               mPtr   = (mOwner + 1) % NR;
               mOwner = -1;
            end
         end
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
